lut4_sweep_ctrl: RTL and testbench

LUT4_SWEEP_CTRL -- requirements
Module: lut4_sweep_ctrl

---
 rtl/lut4_sweep_pkg.sv | 11 +
 rtl/lut4_sweep_if.sv | 31 +++
 rtl/lut4_sweep_idx_counter.sv | 20 ++
 rtl/lut4_sweep_ctrl.sv | 81 ++++++++
 tb/tb_lut4_sweep_ctrl.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/lut4_sweep_pkg.sv
// Shared types and constants for the LUT4 truth-table sweep controller.
package lut4_sweep_pkg;
  localparam int LUT4_ENTRIES = 16;
  localparam int LUT4_IDX_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/lut4_sweep_if.sv
// Request/result handshake plus the drive/response pins of the external LUT4 block.
interface lut4_sweep_if;
  import lut4_sweep_pkg::*;

  logic                    in_val;
  logic                    in_rdy;
  logic [LUT4_ENTRIES-1:0] expected;
  logic                    abort;
  logic                    a;
  logic                    b;
  logic                    c;
  logic                    d;
  logic                    f;
  logic                    out_val;
  logic                    out_rdy;
  logic [LUT4_ENTRIES-1:0] result;
  logic                    match;
  logic                    busy;

  // Requester / function-block side.
  modport master (
    output in_val, expected, abort, f, out_rdy,
    input  in_rdy, a, b, c, d, out_val, result, match, busy
  );

  // Controller side.
  modport slave (
    input  in_val, expected, abort, f, out_rdy,
    output in_rdy, a, b, c, d, out_val, result, match, busy
  );
endinterface

// File: rtl/lut4_sweep_idx_counter.sv
// Input-index counter: clear has priority over enable; wraps naturally.
module lut4_sweep_idx_counter
  import lut4_sweep_pkg::*;
#(
  parameter int W = LUT4_IDX_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  // Count register: reset/clear to zero, otherwise step when enabled.
  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (en)      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/lut4_sweep_ctrl.sv
// Sweeps an external 4-input function block through all 16 input codes,
// captures its truth table and compares it against a golden table.
module lut4_sweep_ctrl
  import lut4_sweep_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  lut4_sweep_if.slave bus
);

  state_e                  state_q, state_d;
  logic [LUT4_IDX_W-1:0]   idx;
  logic [LUT4_ENTRIES-1:0] result_q;
  logic [LUT4_ENTRIES-1:0] exp_q;
  logic                    accept;
  logic                    sweeping;
  logic                    last;

  assign accept   = bus.in_val && (state_q == IDLE);
  assign sweeping = (state_q == SWEEP);
  assign last     = (idx == LUT4_IDX_W'(LUT4_ENTRIES - 1));

  // idx is zero whenever the controller is not sweeping: it is cleared on
  // accept and abort, and the final increment wraps 15 -> 0 as we enter DONE.
  // That lets a..d come straight from the counter flops.
  lut4_sweep_idx_counter #(.W(LUT4_IDX_W)) u_idx (
    .clk   (clk),
    .reset (reset),
    .clr   (accept || (sweeping && bus.abort)),
    .en    (sweeping && !bus.abort),
    .cnt   (idx)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; abort beats the final sweep step.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_val)      state_d = SWEEP;
      SWEEP: begin
        if (bus.abort)              state_d = IDLE;
        else if (last)              state_d = DONE;
      end
      DONE:    if (bus.out_rdy)     state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // Capture golden table on accept and sample f into result[idx] each sweep cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      exp_q    <= '0;
    end else if (accept) begin
      result_q <= '0;
      exp_q    <= bus.expected;
    end else if (sweeping) begin
      if (bus.abort) result_q      <= '0;
      else           result_q[idx] <= bus.f;
    end
  end

  // Outputs decoded from state; match is only asserted alongside out_val.
  always_comb begin
    bus.in_rdy  = (state_q == IDLE);
    bus.busy    = (state_q == SWEEP);
    bus.out_val = (state_q == DONE);
    bus.result  = result_q;
    bus.match   = (state_q == DONE) && (result_q == exp_q);
    bus.a       = idx[3];
    bus.b       = idx[2];
    bus.c       = idx[1];
    bus.d       = idx[0];
  end

endmodule

// File: tb/tb_lut4_sweep_ctrl.sv
// Self-checking bench: the function block is a lookup table held here, and
// the reference outcome of a completed sweep is simply that table and its
// equality with the golden table.
module tb_lut4_sweep_ctrl;
  logic clk = 1'b0;
  logic reset;
  lut4_sweep_if bus();
  logic [15:0] tbl;
  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  assign bus.f = tbl[{bus.a, bus.b, bus.c, bus.d}];

  lut4_sweep_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] abcd();
    return {bus.a, bus.b, bus.c, bus.d};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_rdy"},  32'(bus.in_rdy),  32'd1);
    chk({tag, "_busy"},    32'(bus.busy),    32'd0);
    chk({tag, "_out_val"}, 32'(bus.out_val), 32'd0);
    chk({tag, "_abcd"},    32'(abcd()),      32'd0);
    chk({tag, "_result"},  32'(bus.result),  32'd0);
    chk({tag, "_match"},   32'(bus.match),   32'd0);
  endtask

  // Issue a request from IDLE; afterwards the DUT is in its first sweep cycle.
  task automatic start_req(input logic [15:0] t, input logic [15:0] e, input bit hold);
    tbl = t;
    bus.expected = e;
    bus.in_val = 1'b1;
    chk("req_in_rdy", 32'(bus.in_rdy), 32'd1);
    step();
    if (!hold) bus.in_val = 1'b0;
  endtask

  // Walk the 16 sweep cycles; optionally abort or reset at a given index.
  task automatic sweep_body(input int abort_at, input int reset_at, output bit ended);
    ended = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("sw_busy",    32'(bus.busy),    32'd1);
      chk("sw_in_rdy",  32'(bus.in_rdy),  32'd0);
      chk("sw_out_val", 32'(bus.out_val), 32'd0);
      chk("sw_abcd",    32'(abcd()),      32'(i));
      if (i == abort_at) bus.abort = 1'b1;
      if (i == reset_at) reset = 1'b1;
      step();
      bus.abort = 1'b0;
      reset = 1'b0;
      if (i == abort_at || i == reset_at) begin
        chk_idle(i == abort_at ? "abort" : "midreset");
        return;
      end
    end
    ended = 1'b1;
  endtask

  // Check the DONE result against the reference, stall, then release.
  task automatic finish(input logic [15:0] t, input logic [15:0] e, input int stall);
    logic ref_match;
    ref_match = (t == e);
    for (int s = 0; s <= stall; s++) begin
      chk("done_out_val", 32'(bus.out_val), 32'd1);
      chk("done_in_rdy",  32'(bus.in_rdy),  32'd0);
      chk("done_abcd",    32'(abcd()),      32'd0);
      chk("done_result",  32'(bus.result),  32'(t));
      chk("done_match",   32'(bus.match),   32'(ref_match));
      if (s < stall) begin
        bus.out_rdy = 1'b0;
        bus.in_val  = 1'b1;              // must be ignored in DONE
        bus.abort   = (s == 1);          // no effect in DONE
        tbl = 16'($urandom);             // no resampling of f allowed
        step();
        bus.in_val = 1'b0;
        bus.abort  = 1'b0;
      end else begin
        bus.out_rdy = 1'b1;
        step();
      end
    end
    chk("rel_out_val", 32'(bus.out_val), 32'd0);
    chk("rel_in_rdy",  32'(bus.in_rdy),  32'd1);
    chk("rel_busy",    32'(bus.busy),    32'd0);
  endtask

  initial begin
    bit ended;
    logic [15:0] t, e;
    reset = 1'b1;
    bus.in_val = 1'b0;
    bus.expected = 16'h0;
    bus.abort = 1'b0;
    bus.out_rdy = 1'b1;
    tbl = 16'h0;
    step(); step();
    reset = 1'b0;
    chk_idle("reset");

    // Abort while idle does nothing.
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk_idle("idle_abort");

    // Matching golden table.
    start_req(16'hA533, 16'hA533, 1'b0);
    sweep_body(-1, -1, ended);
    chk("ex1_ended", 32'(ended), 32'd1);
    finish(16'hA533, 16'hA533, 0);

    // One-bit golden mismatch.
    start_req(16'hA533, 16'hA532, 1'b0);
    sweep_body(-1, -1, ended);
    finish(16'hA533, 16'hA532, 0);

    // Consumer stalls for 5 cycles in DONE.
    bus.out_rdy = 1'b0;
    start_req(16'h5AC3, 16'h5AC3, 1'b0);
    sweep_body(-1, -1, ended);
    finish(16'h5AC3, 16'h5AC3, 5);

    // Abort at idx 7, then a normal sweep.
    start_req(16'hFFFF, 16'hFFFF, 1'b0);
    sweep_body(7, -1, ended);
    chk("abort7_ended", 32'(ended), 32'd0);
    step();
    chk_idle("abort7_after");
    start_req(16'h1234, 16'h1234, 1'b0);
    sweep_body(-1, -1, ended);
    finish(16'h1234, 16'h1234, 0);

    // Reset at idx 10.
    start_req(16'hBEEF, 16'hBEEF, 1'b0);
    sweep_body(-1, 10, ended);
    chk("reset10_ended", 32'(ended), 32'd0);

    // Abort on the final sweep cycle with in_val held: restart is immediate.
    start_req(16'hC0DE, 16'hC0DE, 1'b1);
    sweep_body(15, -1, ended);
    chk("abort15_ended", 32'(ended), 32'd0);
    t = 16'h0F0F;
    tbl = t;
    bus.expected = t;
    step();                              // accept edge from IDLE
    bus.in_val = 1'b0;
    sweep_body(-1, -1, ended);
    chk("restart_ended", 32'(ended), 32'd1);
    finish(t, t, 0);

    // Random tables, golden either equal or with one flipped bit.
    for (int n = 0; n < 8; n++) begin
      t = 16'($urandom);
      e = (n % 2 == 0) ? t : (t ^ (16'h1 << $urandom_range(15, 0)));
      start_req(t, e, 1'b0);
      sweep_body(-1, -1, ended);
      finish(t, e, int'($urandom_range(2, 0)));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
